chunked_comparator: RTL and testbench



---
 rtl/chunked_comparator_pkg.sv | 16 +
 rtl/chunked_comparator_chunk_cmp.sv | 26 ++
 rtl/chunked_comparator.sv | 139 +++++++++++++
 tb/tb_chunked_comparator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/chunked_comparator_pkg.sv
// Shared types for the chunked magnitude comparator.
// Holds the control FSM encoding and the chunk-index width helper.
package chunked_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Width of the chunk index; a single-chunk build still needs one bit.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunked_comparator_chunk_cmp.sv
// Combinational CHUNK-bit unsigned magnitude compare.
// flip_msb inverts the top bit of both operands, turning it into a two's-complement compare.
module chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             flip_msb,
   output logic             chunk_gt,
   output logic             chunk_lt
);

   logic [CHUNK-1:0] a_adj;
   logic [CHUNK-1:0] b_adj;

   always_comb begin
      a_adj            = a;
      b_adj            = b;
      a_adj[CHUNK-1]   = a[CHUNK-1] ^ flip_msb;
      b_adj[CHUNK-1]   = b[CHUNK-1] ^ flip_msb;
   end

   assign chunk_gt = (a_adj > b_adj);
   assign chunk_lt = (a_adj < b_adj);

endmodule

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first and
// stops at the first differing chunk, giving registered gt/lt/eq results.
module chunked_comparator
   import chunked_comparator_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CHUNK     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

   state_t            state_reg, state_next;
   logic [IDXW-1:0]   idx_reg, idx_next;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic              mode_reg;
   logic              gt_reg, gt_next;
   logic              lt_reg, lt_next;
   logic              eq_reg, eq_next;
   logic              load;

   logic [CHUNK-1:0]  a_chunks [NCHUNK];
   logic [CHUNK-1:0]  b_chunks [NCHUNK];
   logic [CHUNK-1:0]  a_sel, b_sel;
   logic              flip_msb;
   logic              chunk_gt, chunk_lt;

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
         assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
         assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_reg == IDXW'(i)) begin
            a_sel = a_chunks[i];
            b_sel = b_chunks[i];
         end
      end
   end

   // Only the sign-carrying top chunk is compared as two's complement.
   assign flip_msb = mode_reg && (idx_reg == IDX_TOP);

   chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .a        (a_sel),
      .b        (b_sel),
      .flip_msb (flip_msb),
      .chunk_gt (chunk_gt),
      .chunk_lt (chunk_lt)
   );

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      gt_next    = gt_reg;
      lt_next    = lt_reg;
      eq_next    = eq_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = COMPARE;
               idx_next   = IDX_TOP;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         COMPARE: begin
            if (chunk_gt || chunk_lt) begin
               gt_next    = chunk_gt;
               lt_next    = chunk_lt;
               eq_next    = 1'b0;
               state_next = DONE;
            end else if (idx_reg == '0) begin
               gt_next    = 1'b0;
               lt_next    = 1'b0;
               eq_next    = 1'b1;
               state_next = DONE;
            end else begin
               idx_next   = idx_reg - IDXW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= IDX_TOP;
         a_reg     <= '0;
         b_reg     <= '0;
         mode_reg  <= 1'b0;
         gt_reg    <= 1'b0;
         lt_reg    <= 1'b0;
         eq_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         gt_reg    <= gt_next;
         lt_reg    <= lt_next;
         eq_reg    <= eq_next;
         if (load) begin
            a_reg    <= a;
            b_reg    <= b;
            mode_reg <= signed_mode & SIGNED_EN;
         end
      end
   end

   assign busy = (state_reg == COMPARE);
   assign done = (state_reg == DONE);
   assign gt   = gt_reg;
   assign lt   = lt_reg;
   assign eq   = eq_reg;

endmodule

// File: tb/tb_chunked_comparator.sv
// Randomised self-checking bench for chunked_comparator (32/8 and 16/16 builds)
// against an arithmetic reference model of result and latency.
module tb_chunked_comparator;

   logic        clk;
   logic        rst;
   logic        start, signed_mode;
   logic [31:0] a, b;
   logic        busy, done, gt, lt, eq;
   logic        start16, signed_mode16;
   logic [15:0] a16, b16;
   logic        busy16, done16, gt16, lt16, eq16;

   int n_vec = 0;
   int n_err = 0;

   chunked_comparator #(.WIDTH(32), .CHUNK(8), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
   );

   chunked_comparator #(.WIDTH(16), .CHUNK(16), .SIGNED_EN(1'b1)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(signed_mode16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .gt(gt16), .lt(lt16), .eq(eq16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: signed/unsigned value comparison plus position of the top differing chunk.
   task automatic model(input logic [31:0] x, input logic [31:0] y, input logic m,
                        input int w, input int ch,
                        output logic egt, output logic elt, output logic eeq, output int lat);
      longint vx, vy, cmask;
      int     nch;
      vx = longint'(x);
      vy = longint'(y);
      if (m) begin
         if (x[w-1]) vx = vx - (64'sd1 <<< w);
         if (y[w-1]) vy = vy - (64'sd1 <<< w);
      end
      egt = (vx > vy);
      elt = (vx < vy);
      eeq = (vx == vy);
      nch = w / ch;
      cmask = (64'sd1 <<< ch) - 1;
      lat = nch;
      for (int k = nch - 1; k >= 0; k--) begin
         if (((longint'(x) >>> (k*ch)) & cmask) != ((longint'(y) >>> (k*ch)) & cmask)) begin
            lat = nch - k;
            break;
         end
      end
   endtask

   task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic tm);
      a = ta; b = tb_v; signed_mode = tm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called just after the accepting edge; scribbles on a/b while busy and
   // optionally re-pulses start on busy cycle 'poke'.
   task automatic finish_cmp(input logic [31:0] ta, input logic [31:0] tb_v, input logic tm,
                             input int poke, input string tag);
      logic egt, elt, eeq;
      int   lat, cyc, busy_cnt;
      model(ta, tb_v, tm, 32, 8, egt, elt, eeq, lat);
      cyc = 0;
      busy_cnt = 0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         a = $urandom; b = $urandom; signed_mode = 1'($urandom);
         start = (cyc == poke);
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_gt"}, 32'(gt), 32'(egt));
      check({tag, "_lt"}, 32'(lt), 32'(elt));
      check({tag, "_eq"}, 32'(eq), 32'(eeq));
      $display("txn %s a=%08h b=%08h signed=%0d -> gt=%0d lt=%0d eq=%0d cycles=%0d",
               tag, ta, tb_v, tm, gt, lt, eq, cyc);
   endtask

   task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm,
                        input string tag);
      logic egt, elt, eeq;
      int   lat, cyc;
      model(32'(ta), 32'(tb_v), tm, 16, 16, egt, elt, eeq, lat);
      a16 = ta; b16 = tb_v; signed_mode16 = tm; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      cyc = 0;
      while (!done16 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      check({tag, "_gt"}, 32'(gt16), 32'(egt));
      check({tag, "_lt"}, 32'(lt16), 32'(elt));
      check({tag, "_eq"}, 32'(eq16), 32'(eeq));
      $display("txn %s a=%04h b=%04h signed=%0d -> gt=%0d lt=%0d eq=%0d cycles=%0d",
               tag, ta, tb_v, tm, gt16, lt16, eq16, cyc);
   endtask

   initial begin
      logic [31:0] ra, rb, mask;
      logic        rm;
      int          r;

      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      start16 = 1'b0; signed_mode16 = 1'b0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
      check("rst_outputs16", {27'd0, busy16, done16, gt16, lt16, eq16}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      launch(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      finish_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, -1, "eq_deadbeef");
      launch(32'h80000000, 32'h7FFFFFFF, 1'b0);
      finish_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, -1, "msb_unsigned");
      launch(32'h80000000, 32'h7FFFFFFF, 1'b1);
      finish_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, -1, "msb_signed");
      launch(32'h12345678, 32'h12345679, 1'b0);
      finish_cmp(32'h12345678, 32'h12345679, 1'b0, -1, "lsb_lt");
      launch(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
      finish_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, -1, "neg1_vs_neg2");

      // Start while busy must be ignored; start on the DONE cycle chains directly.
      launch(32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
      finish_cmp(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1, "start_while_busy");
      launch(32'h00000005, 32'h00000009, 1'b1);
      finish_cmp(32'h00000005, 32'h00000009, 1'b1, -1, "back_to_back");

      // Reset on the second COMPARE cycle aborts with no done pulse.
      launch(32'h55AA55AA, 32'h55AA55AA, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
      repeat (5) begin
         @(posedge clk); #1;
         check("abort_no_done", 32'(done), 32'd0);
      end
      launch(32'h0000FF00, 32'h0000FE00, 1'b0);
      finish_cmp(32'h0000FF00, 32'h0000FE00, 1'b0, -1, "after_abort");

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rm = 1'($urandom);
         r  = $urandom_range(0, 4);
         mask = (r == 4) ? 32'hFFFFFFFF : ((32'd1 << (r*8)) - 32'd1);
         rb = (ra & ~mask) | (32'($urandom) & mask);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         launch(ra, rb, rm);
         finish_cmp(ra, rb, rm, ($urandom_range(0, 3) == 0) ? 0 : -1, "rand");
      end

      @(negedge clk);
      run16(16'h0001, 16'h0002, 1'b0, "w16_lt");
      run16(16'h8000, 16'h0001, 1'b1, "w16_signed");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         run16(16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
